// File: rtl/bcd_conv_seq_if.sv
// Handshake and data bundle between the time/date counters and the sequential BCD converter.
// The master drives the requests and snapshot inputs; the slave returns the committed BCD fields.
interface bcd_conv_seq_if #(
  parameter int N_CH   = 3,
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2
);
  logic                       start;
  logic [N_CH*BIN_W-1:0]      bin_in;
  logic                       busy;
  logic                       done;
  logic [N_CH*4*DIGITS-1:0]   bcd_out;
  logic [N_CH-1:0]            ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );
endinterface

// File: rtl/bcd_conv_seq.sv
// Multi-channel sequential binary-to-BCD converter (shift-and-add-3) with an atomic commit
// of every channel, so the display never observes a partially updated time.
module bcd_conv_seq #(
  parameter int N_CH       = 3,
  parameter int BIN_W      = 7,
  parameter int DIGITS     = 2,
  parameter int CONTINUOUS = 0
) (
  input  logic           clk,
  input  logic           rst,
  bcd_conv_seq_if.slave  conv
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CH_N   = 2 ** CH_W;
  localparam int SC_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(BIN_W - 1);
  localparam bit CONT = (CONTINUOUS != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_STORE,
    S_COMMIT
  } state_t;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] >= 4'd5) r[4*d +: 4] = v[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] sat(input logic ovf_f, input logic [BCD_W-1:0] v);
    return ovf_f ? {DIGITS{4'h9}} : v;
  endfunction

  state_t            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [SC_W-1:0]   sc_q;
  logic [BIN_W-1:0]  bin_sh_q;
  logic [BCD_W-1:0]  bcd_sc_q;
  logic              ovf_sc_q;
  logic              busy_q;
  logic              done_q;
  logic [N_CH*BCD_W-1:0] bcd_out_q;
  logic [N_CH-1:0]   ovf_q;

  // Arrays are padded to a power of two so the channel index always matches their depth.
  logic [BIN_W-1:0]  snap_q      [CH_N];
  logic [BCD_W-1:0]  stage_q     [CH_N];
  logic              ovf_stage_q [CH_N];

  logic [BCD_W-1:0]  bcd_adj_d;
  logic [BCD_W-1:0]  bcd_sh_d;
  logic [BIN_W-1:0]  bin_sh_d;
  logic              ovf_sc_d;

  always_comb begin
    bcd_adj_d              = add3(bcd_sc_q);
    {bcd_sh_d, bin_sh_d}   = {bcd_adj_d, bin_sh_q} << 1;
    ovf_sc_d               = ovf_sc_q | bcd_adj_d[BCD_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      sc_q      <= '0;
      bin_sh_q  <= '0;
      bcd_sc_q  <= '0;
      ovf_sc_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_out_q <= '0;
      ovf_q     <= '0;
      for (int i = 0; i < CH_N; i++) begin
        snap_q[i]      <= '0;
        stage_q[i]     <= '0;
        ovf_stage_q[i] <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (CONT || conv.start) begin
            for (int i = 0; i < N_CH; i++) snap_q[i] <= conv.bin_in[i*BIN_W +: BIN_W];
            ch_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          bin_sh_q <= snap_q[ch_q];
          bcd_sc_q <= '0;
          ovf_sc_q <= 1'b0;
          sc_q     <= '0;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd_sc_q <= bcd_sh_d;
          bin_sh_q <= bin_sh_d;
          ovf_sc_q <= ovf_sc_d;
          if (sc_q == SC_LAST) state_q <= S_STORE;
          else                 sc_q    <= sc_q + 1'b1;
        end
        S_STORE: begin
          stage_q[ch_q]     <= sat(ovf_sc_q, bcd_sc_q);
          ovf_stage_q[ch_q] <= ovf_sc_q;
          if (ch_q == CH_LAST) begin
            state_q <= S_COMMIT;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < N_CH; i++) begin
            bcd_out_q[i*BCD_W +: BCD_W] <= stage_q[i];
            ovf_q[i]                    <= ovf_stage_q[i];
          end
          done_q <= 1'b1;
          // Free-running mode snapshots the next pass on the very edge that commits this one.
          if (CONT) begin
            for (int i = 0; i < N_CH; i++) snap_q[i] <= conv.bin_in[i*BIN_W +: BIN_W];
            ch_q    <= '0;
            state_q <= S_LOAD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign conv.busy    = busy_q;
  assign conv.done    = done_q;
  assign conv.bcd_out = bcd_out_q;
  assign conv.ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed and randomized bench for bcd_conv_seq: default, wide single-channel and free-running builds.
module tb_bcd_conv_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bcd_conv_seq_if #(.N_CH(3), .BIN_W(7),  .DIGITS(2)) if_def ();
  bcd_conv_seq_if #(.N_CH(1), .BIN_W(14), .DIGITS(4)) if_wide ();
  bcd_conv_seq_if #(.N_CH(3), .BIN_W(7),  .DIGITS(2)) if_cont ();

  bcd_conv_seq #(.N_CH(3), .BIN_W(7),  .DIGITS(2), .CONTINUOUS(0)) u_def  (.clk(clk), .rst(rst), .conv(if_def));
  bcd_conv_seq #(.N_CH(1), .BIN_W(14), .DIGITS(4), .CONTINUOUS(0)) u_wide (.clk(clk), .rst(rst), .conv(if_wide));
  bcd_conv_seq #(.N_CH(3), .BIN_W(7),  .DIGITS(2), .CONTINUOUS(1)) u_cont (.clk(clk), .rst(rst), .conv(if_cont));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: saturate to 10^digits-1, then peel decimal digits.
  function automatic logic [15:0] ref_ch(input int v, input int digits, output logic ov);
    int lim;
    int x;
    logic [15:0] r;
    lim = 1;
    for (int d = 0; d < digits; d++) lim = lim * 10;
    ov = (v >= lim);
    x  = ov ? lim - 1 : v;
    r  = '0;
    for (int d = 0; d < digits; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model3(input int c0, input int c1, input int c2,
                        output logic [23:0] eb, output logic [2:0] eo);
    logic [15:0] r;
    logic        ov;
    r = ref_ch(c0, 2, ov); eb[7:0]   = r[7:0]; eo[0] = ov;
    r = ref_ch(c1, 2, ov); eb[15:8]  = r[7:0]; eo[1] = ov;
    r = ref_ch(c2, 2, ov); eb[23:16] = r[7:0]; eo[2] = ov;
  endtask

  task automatic run_def(input int c0, input int c1, input int c2);
    logic [23:0] eb;
    logic [2:0]  eo;
    int          lat;
    model3(c0, c1, c2, eb, eo);
    if_def.bin_in = {7'(c2), 7'(c1), 7'(c0)};
    if_def.start  = 1'b1;
    @(negedge clk);
    if_def.start  = 1'b0;
    check("def_busy_after_accept", 32'(if_def.busy), 32'd1);
    lat = 0;
    while (!if_def.done && lat < 60) begin @(negedge clk); lat++; end
    check("def_latency", lat, 28);
    check("def_bcd", 32'(if_def.bcd_out), 32'(eb));
    check("def_ovf", 32'(if_def.ovf), 32'(eo));
    check("def_busy_at_done", 32'(if_def.busy), 32'd0);
  endtask

  task automatic run_wide(input int v);
    logic [15:0] eb;
    logic        eo;
    int          lat;
    eb = ref_ch(v, 4, eo);
    if_wide.bin_in = 14'(v);
    if_wide.start  = 1'b1;
    @(negedge clk);
    if_wide.start  = 1'b0;
    check("wide_busy_after_accept", 32'(if_wide.busy), 32'd1);
    lat = 0;
    while (!if_wide.done && lat < 60) begin @(negedge clk); lat++; end
    check("wide_latency", lat, 17);
    check("wide_bcd", 32'(if_wide.bcd_out), 32'(eb));
    check("wide_ovf", 32'(if_wide.ovf), 32'(eo));
  endtask

  initial begin
    logic [23:0] eb;
    logic [2:0]  eo;
    int          lat;
    int          ndone;
    int          r1;
    int          r2;

    if_def.start  = 1'b0; if_def.bin_in  = '0;
    if_wide.start = 1'b0; if_wide.bin_in = '0;
    if_cont.start = 1'b0; if_cont.bin_in = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(if_def.busy), 32'd0);
    check("rst_done", 32'(if_def.done), 32'd0);
    check("rst_bcd",  32'(if_def.bcd_out), 32'd0);
    check("rst_ovf",  32'(if_def.ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversion and its single-cycle done pulse
    run_def(59, 7, 23);
    check("t1_bcd_const", 32'(if_def.bcd_out), 32'h230759);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(if_def.done), 32'd0);
    check("t1_hold_bcd", 32'(if_def.bcd_out), 32'h230759);

    // Overflow on one channel, exact 99 on another, zero on the third
    run_def(127, 99, 0);
    check("t2_bcd_const", 32'(if_def.bcd_out), 32'h009999);
    check("t2_ovf_const", 32'(if_def.ovf), 32'h1);

    for (int i = 0; i < 8; i++)
      run_def(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));

    // Starts and input changes while busy are ignored
    model3(10, 0, 0, eb, eo);
    if_def.bin_in = {7'd0, 7'd0, 7'd10};
    if_def.start  = 1'b1;
    @(negedge clk);
    if_def.start  = 1'b0;
    ndone = 0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (if_def.done) ndone++;
      if_def.start = (cyc == 5 || cyc == 20);
      if (cyc == 5 || cyc == 20) if_def.bin_in = 21'($urandom);
    end
    if_def.start = 1'b0;
    check("t3_single_done", ndone, 1);
    check("t3_bcd_ch0", 32'(if_def.bcd_out[7:0]), 32'h10);
    check("t3_bcd_all", 32'(if_def.bcd_out), 32'(eb));
    check("t3_idle", 32'(if_def.busy), 32'd0);

    // Reset in the middle of a pass discards it and clears the outputs
    run_def(45, 0, 0);
    check("t4_pre_bcd", 32'(if_def.bcd_out[7:0]), 32'h45);
    if_def.bin_in = 21'($urandom);
    if_def.start  = 1'b1;
    @(negedge clk);
    if_def.start  = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t4_rst_bcd",  32'(if_def.bcd_out), 32'd0);
    check("t4_rst_busy", 32'(if_def.busy), 32'd0);
    check("t4_rst_done", 32'(if_def.done), 32'd0);
    check("t4_rst_ovf",  32'(if_def.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (if_def.done) ndone++;
    end
    check("t4_no_done", ndone, 0);
    check("t4_bcd_held_zero", 32'(if_def.bcd_out), 32'd0);
    run_def(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));

    // Wide single-channel build
    run_wide(9999);
    check("t6_9999", 32'(if_wide.bcd_out), 32'h9999);
    run_wide(2025);
    check("t6_2025", 32'(if_wide.bcd_out), 32'h2025);
    run_wide(0);
    run_wide(16383);
    check("t6_ovf", 32'(if_wide.ovf), 32'd1);
    for (int i = 0; i < 4; i++) run_wide(int'($urandom_range(0, 16383)));

    // Free-running build: each commit shows the value captured at the previous commit
    rst = 1'b1;
    r1 = int'($urandom_range(0, 127));
    r2 = int'($urandom_range(0, 127));
    if_cont.bin_in = {7'(r2), 7'(r1), 7'd0};
    @(negedge clk);
    rst = 1'b0;
    model3(0, r1, r2, eb, eo);
    lat = 0;
    while (!if_cont.done && lat < 60) begin @(negedge clk); lat++; end
    check("t5_first_latency", lat, 29);
    for (int k = 1; k < 60; k++) begin
      check("t5_bcd", 32'(if_cont.bcd_out), 32'(eb));
      check("t5_ovf", 32'(if_cont.ovf), 32'(eo));
      check("t5_busy", 32'(if_cont.busy), 32'd1);
      model3(int'(if_cont.bin_in[6:0]), int'(if_cont.bin_in[13:7]), int'(if_cont.bin_in[20:14]), eb, eo);
      r1 = int'($urandom_range(0, 127));
      r2 = int'($urandom_range(0, 127));
      if_cont.bin_in = {7'(r2), 7'(r1), 7'(k)};
      lat = 0;
      @(negedge clk); lat++;
      while (!if_cont.done && lat < 60) begin @(negedge clk); lat++; end
      check("t5_period", lat, 28);
    end
    check("t5_last_bcd", 32'(if_cont.bcd_out), 32'(eb));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
